// File: rtl/alu_op_sequencer.sv
// Issue stage in front of the ALU: accepts a request, holds it on the ALU inputs for DRIVE and SAMPLE, then returns OutALU and Flags.
// Optional performance counter enabled by defining ALU_SEQ_PERF_CNT_EN.
module alu_op_sequencer #(
    parameter int WIDTH    = 8,
    parameter int FUNSEL_W = 4,
    parameter int FLAG_W   = 4
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [FUNSEL_W-1:0] req_funsel,
    input  logic [WIDTH-1:0]    req_a,
    input  logic [WIDTH-1:0]    req_b,
    input  logic                req_use_prev,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [FUNSEL_W-1:0] alu_funsel,
    input  logic [WIDTH-1:0]    alu_out,
    input  logic [FLAG_W-1:0]   alu_flags,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic [FLAG_W-1:0]   rsp_flags
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        RESP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic [FUNSEL_W-1:0]   funsel_q;
    logic [WIDTH-1:0]      prev_result;
    logic                  accept;
    logic                  rsp_fire;
    logic                  alu_busy;

    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign alu_busy  = (state == DRIVE) || (state == SAMPLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = DRIVE;
            DRIVE:   state_next = SAMPLE;
            SAMPLE:  state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = accept ? DRIVE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // In RESP prev_result already equals the rsp_data being handed off, so chaining sees it directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            funsel_q <= '0;
        end else if (accept) begin
            a_q      <= req_use_prev ? prev_result : req_a;
            b_q      <= req_b;
            funsel_q <= req_funsel;
        end
    end

    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_funsel = '0;
        if (alu_busy) begin
            alu_a      = a_q;
            alu_b      = b_q;
            alu_funsel = funsel_q;
        end
    end

    // Flags were clocked by the ALU at the end of DRIVE, so both values are settled by the end of SAMPLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_flags   <= '0;
            prev_result <= '0;
        end else if (state == SAMPLE) begin
            rsp_valid   <= 1'b1;
            rsp_data    <= alu_out;
            rsp_flags   <= alu_flags;
            prev_result <= alu_out;
        end else if (rsp_fire) begin
            rsp_valid   <= 1'b0;
        end
    end

`ifdef ALU_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (rsp_fire) begin
            op_count <= op_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a small ALU model drives alu_out/alu_flags, a transaction model predicts every output each cycle.
// Define ALU_SEQ_PERF_CNT_EN to also exercise op_count (counter narrowed to 4 bits so wrap is reachable).
module tb_alu_op_sequencer;

    localparam logic [3:0] F_ADD = 4'b0100;
    localparam logic [3:0] F_SUB = 4'b0101;
    localparam logic [3:0] F_LSL = 4'b1011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_funsel = '0;
    logic [7:0] req_a = '0;
    logic [7:0] req_b = '0;
    logic       req_use_prev = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_funsel;
    logic [7:0] alu_out;
    logic [3:0] alu_flags = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
`ifdef ALU_SEQ_PERF_CNT_EN
    logic [3:0] op_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef ALU_SEQ_PERF_CNT_EN
    alu_op_sequencer #(.WIDTH(8), .FUNSEL_W(4), .FLAG_W(4), .CNT_W(4)) dut (
`else
    alu_op_sequencer #(.WIDTH(8), .FUNSEL_W(4), .FLAG_W(4)) dut (
`endif
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_funsel(req_funsel),
        .req_a(req_a), .req_b(req_b), .req_use_prev(req_use_prev),
        .alu_a(alu_a), .alu_b(alu_b), .alu_funsel(alu_funsel),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags)
`ifdef ALU_SEQ_PERF_CNT_EN
        , .op_count(op_count)
`endif
    );

    // ALU behaviour: returns {Z,C,N,O, result}
    function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       o;
        case (f)
            F_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0]; c = s[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            F_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 9'd1;
                r = s[7:0]; c = s[8];
                o = (a[7] != b[7]) && (r[7] != a[7]);
            end
            F_LSL: begin
                r = {a[6:0], 1'b0}; c = a[7];
                o = a[7] ^ r[7];
            end
            default: begin
                r = a; c = 1'b0; o = 1'b0;
            end
        endcase
        return {(r == 8'h00), c, r[7], o, r};
    endfunction

    logic [11:0] alu_comb;
    assign alu_comb = alu_f(alu_a, alu_b, alu_funsel);
    assign alu_out  = alu_comb[7:0];
    always @(posedge clk) alu_flags <= alu_comb[11:8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted op finishes two cycles later and then waits for rsp_ready.
    bit         m_started = 0;
    bit         m_busy = 0;
    int         m_cd = 0;
    bit         m_pend = 0;
    logic [7:0] m_a = '0, m_b = '0, m_data = '0, m_prev = '0;
    logic [3:0] m_f = '0, m_flags = '0;
    int         m_cnt = 0;

    always @(posedge clk) begin
        bit old_busy, old_pend, ready;
        if (rst) begin
            m_started = 1; m_busy = 0; m_cd = 0; m_pend = 0;
            m_a = '0; m_b = '0; m_f = '0; m_data = '0; m_flags = '0; m_prev = '0; m_cnt = 0;
        end else begin
            old_busy = m_busy;
            old_pend = m_pend;
            ready = (!old_busy && !old_pend) || (old_pend && rsp_ready);
            if (old_pend && rsp_ready) begin
                m_pend = 0;
                m_cnt  = (m_cnt + 1) % 16;
            end
            if (old_busy) begin
                if (m_cd == 1) begin
                    m_busy = 0;
                    m_pend = 1;
                    {m_flags, m_data} = alu_f(m_a, m_b, m_f);
                    m_prev = m_data;
                end else begin
                    m_cd--;
                end
            end
            if (req_valid && ready) begin
                m_a = req_use_prev ? m_prev : req_a;
                m_b = req_b;
                m_f = req_funsel;
                m_busy = 1;
                m_cd = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("req_ready", 32'(req_ready), 32'((!m_busy && !m_pend) || (m_pend && rsp_ready)));
            check("rsp_valid", 32'(rsp_valid), 32'(m_pend));
            check("alu_a", 32'(alu_a), m_busy ? 32'(m_a) : 32'd0);
            check("alu_b", 32'(alu_b), m_busy ? 32'(m_b) : 32'd0);
            check("alu_funsel", 32'(alu_funsel), m_busy ? 32'(m_f) : 32'd0);
            if (m_pend) begin
                check("rsp_data", 32'(rsp_data), 32'(m_data));
                check("rsp_flags", 32'(rsp_flags), 32'(m_flags));
            end
`ifdef ALU_SEQ_PERF_CNT_EN
            check("op_count", 32'(op_count), 32'(m_cnt));
`endif
        end
    end

    // Present a request, wait for acceptance, then wait for the response; returns at the negedge it is seen.
    task automatic run_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b, input logic up,
                          output logic [7:0] data, output logic [3:0] flags, output int lat, output int held);
        bit rdy;
        bit ok;
        req_funsel = f; req_a = a; req_b = b; req_use_prev = up; req_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk) rdy = req_ready;
            @(posedge clk);
            if (rdy) begin ok = 1; break; end
        end
        #1 req_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        lat = 0; held = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (alu_b == b && alu_funsel == f) held++;
            if (rsp_valid) break;
        end
        data = rsp_data;
        flags = rsp_flags;
        if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    logic [7:0] d;
    logic [3:0] fl;
    int         lat, held;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            check("idle_req_ready", 32'(req_ready), 32'd1);
            check("idle_alu_a", 32'(alu_a), 32'd0);
            check("idle_rsp_data", 32'(rsp_data), 32'd0);
        end
        @(posedge clk); #1;

        // Single ADD
        run_op(F_ADD, 8'h33, 8'h0F, 1'b0, d, fl, lat, held);
        check("add_data", 32'(d), 32'h42);
        check("add_flags", 32'(fl), 32'h0);
        check("add_latency", 32'(lat), 32'd3);
        check("add_held_cycles", 32'(held), 32'd2);
        @(posedge clk); #1;

        // Chain: ADD then LSL of previous result, req_a ignored
        run_op(F_ADD, 8'h33, 8'h0F, 1'b0, d, fl, lat, held);
        @(posedge clk); #1;
        run_op(F_LSL, 8'hFF, 8'h00, 1'b1, d, fl, lat, held);
        check("chain_data", 32'(d), 32'h84);
        check("chain_flags", 32'(fl), 32'h3);
        @(posedge clk); #1;

        // Backpressure then same-edge hand-off to a new request
        rsp_ready = 1'b0;
        run_op(F_ADD, 8'h33, 8'h0F, 1'b0, d, fl, lat, held);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'h42);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_funsel = F_SUB; req_a = 8'h07; req_b = 8'h02; req_use_prev = 1'b0; req_valid = 1'b1;
        @(negedge clk) check("handoff_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("handoff_drive_a", 32'(alu_a), 32'h07);
        check("handoff_drive_f", 32'(alu_funsel), 32'(F_SUB));
        check("handoff_valid_low", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("handoff_rsp", 32'(rsp_data), 32'h05);
        @(posedge clk); #1;

        // Reset during DRIVE of SUB 0x07,0xFA
        req_funsel = F_SUB; req_a = 8'h07; req_b = 8'hFA; req_use_prev = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_drive_b", 32'(alu_b), 32'hFA);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_idle_ready", 32'(req_ready), 32'd1);
        check("mid_idle_alu_b", 32'(alu_b), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        run_op(F_ADD, 8'h55, 8'h05, 1'b1, d, fl, lat, held);
        check("prev_zero_data", 32'(d), 32'h05);
        @(posedge clk); #1;

`ifdef ALU_SEQ_PERF_CNT_EN
        pulse_rst();
        for (int i = 0; i < 3; i++) begin
            run_op(F_ADD, 8'(i), 8'h01, 1'b0, d, fl, lat, held);
            @(posedge clk); #1;
        end
        @(negedge clk) check("cnt_three", 32'(op_count), 32'd3);
        for (int i = 0; i < 12; i++) begin
            run_op(F_ADD, 8'h10, 8'(i), 1'b0, d, fl, lat, held);
            @(posedge clk); #1;
        end
        @(negedge clk) check("cnt_max", 32'(op_count), 32'hF);
        run_op(F_LSL, 8'h01, 8'h00, 1'b0, d, fl, lat, held);
        @(posedge clk); #1;
        @(negedge clk) check("cnt_wrap", 32'(op_count), 32'h0);
        run_op(F_ADD, 8'h01, 8'h01, 1'b0, d, fl, lat, held);
        @(posedge clk); #1;
        pulse_rst();
        @(negedge clk) check("cnt_rst", 32'(op_count), 32'h0);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
